layer_0_conv_ctrl: RTL and testbench
====================================

// Module: layer_0_conv_ctrl
// PURPOSE
//  Layer-0 side of the layer_0_en / layer_0_calc_fin handshake driven by network_manager.
//  While enabled, scans every output window of one input image across all kernels:
//  - requests each window from the image buffer;
//  - launches one MAC per kernel.
//  Pulses layer_0_calc_fin once per completed image.
// PARAMETERS
//  IMAGE_WIDTH   32  input image side (pixels, square)
//  KERNEL_SIZE    5  convolution kernel side
//  KERNEL_NUM     6  kernels per window; one MAC each
//  OUT_DIM  = IMAGE_WIDTH-KERNEL_SIZE+1 (localparam, 28); IDX_W = $clog2(OUT_DIM); K_W = $clog2(KERNEL_NUM)
// PORTS
//  clk              in   1      clock
//  rst_n            in   1      reset, synchronous, active-low
//  layer_0_en       in   1      level enable from network_manager
//  win_ack          in   1      image buffer: requested window loaded into MAC operand regs
//  mac_done         in   1      MAC array: current kernel result written
//  win_req          out  1      request window at (win_row, win_col); held until win_ack
//  win_row          out  IDX_W  window top-left row, 0..OUT_DIM-1
//  win_col          out  IDX_W  window top-left col, 0..OUT_DIM-1
//  mac_start        out  1      one-cycle pulse: start MAC with kernel_idx
//  kernel_idx       out  K_W    kernel selector, 0..KERNEL_NUM-1
//  layer_0_calc_fin out  1      one-cycle pulse: image finished
//  busy             out  1      1 in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, all counters 0, state IDLE. Outputs are registered.
//  FSM states: IDLE, LOAD, CALC, WAIT_MAC, FIN.
//   IDLE:     layer_0_en=1 -> LOAD.
//   LOAD:     win_req=1 with stable row/col; win_ack=1 -> CALC, win_req drops next cycle.
//   CALC:     mac_start=1 for exactly one cycle -> WAIT_MAC.
//   WAIT_MAC: wait for mac_done.
//     - kernel_idx<KERNEL_NUM-1: kernel_idx++ -> CALC, no new window request.
//     - else: kernel_idx=0 and advance the window.
//       Advance: col++; col=OUT_DIM-1 wraps to 0 and row++.
//       If row=col=OUT_DIM-1 -> FIN, else -> LOAD.
//   FIN:      layer_0_calc_fin=1 for one cycle; row/col/kernel cleared -> IDLE.
//  Back-to-back images:
//   - network_manager keeps layer_0_en high, so IDLE relaunches on the next cycle.
//   - After the last image, layer_0_en is 0 in the cycle after the pulse; the block stays IDLE.
//  Per-image cycle count:
//   - minimum, with win_ack and mac_done same-cycle: OUT_DIM^2*(1+2*KERNEL_NUM)+2;
//   - otherwise extended by ack/done latency.
//  Abort: layer_0_en=0 in any non-IDLE state (checked before other transitions):
//   - next state IDLE; counters cleared;
//   - no calc_fin; in-flight mac_done ignored.
//  Stray inputs:
//   - mac_done outside WAIT_MAC is ignored;
//   - win_ack outside LOAD is ignored;
//   - win_ack and mac_done together: only the one valid for the current state acts.
//  Synchronous reset mid-image: same as abort, and every output is 0 on the next cycle.
// CONFIGURATION
//  LAYER_0_PERF_CNT_EN defined:
//   - adds output perf_cycles [31:0], the cycle count of the last completed image;
//   - counts while busy and latches on calc_fin;
//   - cleared by reset; abort does not update it.
//  Undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  network_pkg (shared):
//   - typedef enum logic [2:0] l0_state_t {IDLE,LOAD,CALC,WAIT_MAC,FIN};
//   - function out_dim(img,ker).
//  Sub-module window_scan_cnt:
//   - row/col counter with clr, inc, last_win output;
//   - instantiated once; reusable for the pooling layer scan.
// TESTING  (bench params IMAGE_WIDTH=6, KERNEL_SIZE=5 -> OUT_DIM=2, KERNEL_NUM=2)
//  1. Reset, then layer_0_en=1 with win_ack/mac_done tied 1:
//     - windows (0,0),(0,1),(1,0),(1,1) in that order;
//     - 8 mac_start pulses, kernel_idx 0,1 per window;
//     - one calc_fin pulse 22 cycles after enable.
//  2. win_ack delayed 3 cycles: win_req held with stable row/col for 3 cycles; no mac_start before ack.
//  3. layer_0_en held high over 3 images: 3 calc_fin pulses, each followed directly by LOAD of (0,0).
//  4. layer_0_en dropped in WAIT_MAC of window (1,0): busy=0 next cycle; no calc_fin.
//     Re-enable restarts at (0,0), kernel 0.
//  5. mac_done pulsed during LOAD and rst_n=0 during CALC:
//     - stray done does not change kernel_idx;
//     - after reset all outputs are 0.
//  6. LAYER_0_PERF_CNT_EN defined, scenario 1: perf_cycles=22 after calc_fin; unchanged after an aborted run.

Source files
------------

// File: rtl/network_pkg.sv
// Shared types and elaboration helpers for the network layer controllers.
package network_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    WAIT_MAC,
    FIN
  } l0_state_t;

  // Side of the valid-convolution output map.
  function automatic int out_dim(input int img, input int ker);
    return img - ker + 1;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_scan_cnt.sv
// Row/column window position counter for a square DIM x DIM scan.
// Column runs fastest; last_win flags the bottom-right position.
module window_scan_cnt
  import network_pkg::*;
#(
  parameter int DIM = 28,
  parameter int W   = cnt_width(DIM)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         last_win
);

  localparam logic [W-1:0] LAST = W'(DIM - 1);

  // Advance the scan position; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + W'(1);
      end else begin
        col <= col + W'(1);
      end
    end
  end

  assign last_win = (row == LAST) && (col == LAST);

endmodule

// File: rtl/layer_0_conv_ctrl.sv
// Layer-0 convolution controller: walks every output window of one image,
// requests it from the image buffer and launches one MAC per kernel.
// Optional macro LAYER_0_PERF_CNT_EN adds perf_cycles (cycles of the last
// completed image, launch cycle through calc_fin cycle inclusive).
//
//  state    | meaning
//  ---------+----------------------------------------------------
//  IDLE     | waiting for layer_0_en
//  LOAD     | win_req high, waiting for win_ack
//  CALC     | one-cycle mac_start for kernel_idx
//  WAIT_MAC | waiting for mac_done, then next kernel or window
//  FIN      | one-cycle layer_0_calc_fin, counters cleared
module layer_0_conv_ctrl
  import network_pkg::*;
#(
  parameter  int IMAGE_WIDTH = 32,
  parameter  int KERNEL_SIZE = 5,
  parameter  int KERNEL_NUM  = 6,
  localparam int OUT_DIM     = out_dim(IMAGE_WIDTH, KERNEL_SIZE),
  localparam int IDX_W       = cnt_width(OUT_DIM),
  localparam int K_W         = cnt_width(KERNEL_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             layer_0_en,
  input  logic             win_ack,
  input  logic             mac_done,
  output logic             win_req,
  output logic [IDX_W-1:0] win_row,
  output logic [IDX_W-1:0] win_col,
  output logic             mac_start,
  output logic [K_W-1:0]   kernel_idx,
  output logic             layer_0_calc_fin,
`ifdef LAYER_0_PERF_CNT_EN
  output logic [31:0]      perf_cycles,
`endif
  output logic             busy
);

  localparam logic [K_W-1:0] K_LAST = K_W'(KERNEL_NUM - 1);

  l0_state_t state, state_nxt;
  logic      scan_clr, scan_inc, last_win;
  logic      k_clr, k_inc;

  window_scan_cnt #(
    .DIM (OUT_DIM),
    .W   (IDX_W)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (scan_clr),
    .inc      (scan_inc),
    .row      (win_row),
    .col      (win_col),
    .last_win (last_win)
  );

  // Next state and counter controls; a dropped enable aborts from any busy state.
  always_comb begin
    state_nxt = state;
    scan_clr  = 1'b0;
    scan_inc  = 1'b0;
    k_clr     = 1'b0;
    k_inc     = 1'b0;
    if (state != IDLE && !layer_0_en) begin
      state_nxt = IDLE;
      scan_clr  = 1'b1;
      k_clr     = 1'b1;
    end else begin
      case (state)
        IDLE:     if (layer_0_en) state_nxt = LOAD;
        LOAD:     if (win_ack) state_nxt = CALC;
        CALC:     state_nxt = WAIT_MAC;
        WAIT_MAC: begin
          if (mac_done) begin
            if (kernel_idx != K_LAST) begin
              k_inc     = 1'b1;
              state_nxt = CALC;
            end else begin
              k_clr = 1'b1;
              // The last window is not advanced: FIN clears the scan instead.
              if (last_win) begin
                state_nxt = FIN;
              end else begin
                scan_inc  = 1'b1;
                state_nxt = LOAD;
              end
            end
          end
        end
        FIN: begin
          state_nxt = IDLE;
          scan_clr  = 1'b1;
          k_clr     = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register with outputs registered from the next state, so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      win_req          <= 1'b0;
      mac_start        <= 1'b0;
      layer_0_calc_fin <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_nxt;
      win_req          <= (state_nxt == LOAD);
      mac_start        <= (state_nxt == CALC);
      layer_0_calc_fin <= (state_nxt == FIN);
      busy             <= (state_nxt != IDLE);
    end
  end

  // Kernel selector for the current window.
  always_ff @(posedge clk) begin
    if (!rst_n || k_clr) begin
      kernel_idx <= '0;
    end else if (k_inc) begin
      kernel_idx <= kernel_idx + K_W'(1);
    end
  end

`ifdef LAYER_0_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // Running count starts at 1 for the launch cycle; latched including the FIN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else if (state == IDLE && state_nxt == LOAD) begin
      perf_cnt <= 32'd1;
    end else if (state == FIN) begin
      perf_cycles <= perf_cnt + 32'd1;
    end else if (state != IDLE) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_layer_0_conv_ctrl.sv
// Bench for layer_0_conv_ctrl with a 2x2 output map and two kernels.
module tb_layer_0_conv_ctrl;

  localparam int IW      = 6;
  localparam int KS      = 5;
  localparam int KN      = 2;
  localparam int OD      = IW - KS + 1;
  localparam int IDX_W   = (OD > 1) ? $clog2(OD) : 1;
  localparam int K_W     = (KN > 1) ? $clog2(KN) : 1;
  localparam int MIN_CYC = OD * OD * (1 + 2 * KN) + 2;

  localparam int M_ZERO = 0;
  localparam int M_ONE  = 1;
  localparam int M_LAT  = 2;
  localparam int M_MAN  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             layer_0_en = 1'b0;
  logic             win_ack, mac_done;
  logic             win_req;
  logic [IDX_W-1:0] win_row, win_col;
  logic             mac_start;
  logic [K_W-1:0]   kernel_idx;
  logic             layer_0_calc_fin;
  logic             busy;
`ifdef LAYER_0_PERF_CNT_EN
  logic [31:0]      perf_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int   mode = M_ZERO;
  logic man_ack = 1'b0, man_done = 1'b0;
  logic r_ack = 1'b0, r_done = 1'b0;
  int   ack_min = 0, ack_max = 0, done_min = 0, done_max = 0;
  int   extra_total = 0;
  bit   a_armed = 0, d_armed = 0;
  int   a_wait = 0, a_tgt = 0, d_wait = 0, d_tgt = 0;

  always #5 clk = ~clk;

  assign win_ack  = (mode == M_ONE) ? 1'b1 : (mode == M_LAT) ? r_ack  : (mode == M_MAN) ? man_ack  : 1'b0;
  assign mac_done = (mode == M_ONE) ? 1'b1 : (mode == M_LAT) ? r_done : (mode == M_MAN) ? man_done : 1'b0;

  layer_0_conv_ctrl #(
    .IMAGE_WIDTH (IW),
    .KERNEL_SIZE (KS),
    .KERNEL_NUM  (KN)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .layer_0_en       (layer_0_en),
    .win_ack          (win_ack),
    .mac_done         (mac_done),
    .win_req          (win_req),
    .win_row          (win_row),
    .win_col          (win_col),
    .mac_start        (mac_start),
    .kernel_idx       (kernel_idx),
    .layer_0_calc_fin (layer_0_calc_fin),
`ifdef LAYER_0_PERF_CNT_EN
    .perf_cycles      (perf_cycles),
`endif
    .busy             (busy)
  );

  // Latency responder: answers a request after a random number of extra
  // cycles and accumulates the extra cycles the image will take.
  always @(negedge clk) begin
    r_ack  = 1'b0;
    r_done = 1'b0;
    if (mode != M_LAT || !busy) begin
      a_armed = 0;
      d_armed = 0;
    end else begin
      if (win_req) begin
        if (!a_armed) begin
          a_armed = 1;
          a_wait  = 0;
          a_tgt   = ack_min + $urandom_range(0, ack_max - ack_min);
          extra_total += a_tgt;
        end
        if (a_wait == a_tgt) begin
          r_ack   = 1'b1;
          a_armed = 0;
        end else begin
          a_wait++;
        end
      end
      if (!win_req && !mac_start && !layer_0_calc_fin) begin
        if (!d_armed) begin
          d_armed = 1;
          d_wait  = 0;
          d_tgt   = done_min + $urandom_range(0, done_max - done_min);
          extra_total += d_tgt;
        end
        if (d_wait == d_tgt) begin
          r_done  = 1'b1;
          d_armed = 0;
        end else begin
          d_wait++;
        end
      end
    end
  end

  task automatic test_reset();
    mode = M_ZERO;
    rst_n = 1'b0;
    layer_0_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({win_req, win_row, win_col, mac_start, kernel_idx, layer_0_calc_fin, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {win_req, win_row, win_col, mac_start, kernel_idx, layer_0_calc_fin, busy});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || win_req !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_enable: got busy=%b req=%b expected 0 0", busy, win_req);
    end
`ifdef LAYER_0_PERF_CNT_EN
    n_cmp++;
    if (perf_cycles !== 32'd0) begin
      n_err++;
      $display("FAIL perf_reset: got %0d expected 0", perf_cycles);
    end
`endif
  endtask

  // One image with win_ack/mac_done tied high: order of windows and MACs, latency.
  task automatic test_single_image();
    int er[$], ec[$], ek[$], wr[$], wc[$];
    int n, fins, fin_n, macs, idle_bad;
    for (int r = 0; r < OD; r++)
      for (int c = 0; c < OD; c++) begin
        wr.push_back(r);
        wc.push_back(c);
        for (int k = 0; k < KN; k++) begin
          er.push_back(r); ec.push_back(c); ek.push_back(k);
        end
      end
    mode = M_ONE;
    @(negedge clk);
    layer_0_en = 1'b1;
    n = 1; fins = 0; fin_n = 0; macs = 0;
    for (int cyc = 0; cyc < 100 && fins == 0; cyc++) begin
      @(negedge clk);
      n++;
      if (win_req) begin
        n_cmp++;
        if (wr.size() == 0) begin
          n_err++;
          $display("FAIL single_win_extra: got window (%0d,%0d) expected none", win_row, win_col);
        end else begin
          if (int'(win_row) != wr[0] || int'(win_col) != wc[0]) begin
            n_err++;
            $display("FAIL single_win_order: got (%0d,%0d) expected (%0d,%0d)", win_row, win_col, wr[0], wc[0]);
          end
          void'(wr.pop_front()); void'(wc.pop_front());
        end
      end
      if (mac_start) begin
        macs++;
        n_cmp++;
        if (er.size() == 0) begin
          n_err++;
          $display("FAIL single_mac_extra: got mac_start expected none");
        end else begin
          if (int'(win_row) != er[0] || int'(win_col) != ec[0] || int'(kernel_idx) != ek[0]) begin
            n_err++;
            $display("FAIL single_mac_order: got (%0d,%0d,k%0d) expected (%0d,%0d,k%0d)",
                     win_row, win_col, kernel_idx, er[0], ec[0], ek[0]);
          end
          void'(er.pop_front()); void'(ec.pop_front()); void'(ek.pop_front());
        end
      end
      if (layer_0_calc_fin) begin
        fins++;
        fin_n = n;
      end
    end
    n_cmp++;
    if (fin_n != MIN_CYC) begin
      n_err++;
      $display("FAIL single_latency: got %0d expected %0d", fin_n, MIN_CYC);
    end
    n_cmp++;
    if (macs != OD * OD * KN) begin
      n_err++;
      $display("FAIL single_mac_count: got %0d expected %0d", macs, OD * OD * KN);
    end
    @(negedge clk);
    layer_0_en = 1'b0;
    idle_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || layer_0_calc_fin) idle_bad++;
    end
    n_cmp++;
    if (idle_bad != 0) begin
      n_err++;
      $display("FAIL single_stays_idle: got %0d busy cycles expected 0", idle_bad);
    end
  endtask

  // Acknowledge arrives in the third request cycle of every window.
  task automatic test_ack_delay();
    int n, fins, fin_n, run, x0;
    logic prev_req;
    logic [IDX_W-1:0] rr, rc;
    mode = M_LAT;
    ack_min = 2; ack_max = 2; done_min = 0; done_max = 0;
    x0 = extra_total;
    @(negedge clk);
    layer_0_en = 1'b1;
    n = 1; fins = 0; fin_n = 0; run = 0; prev_req = 1'b0; rr = '0; rc = '0;
    for (int cyc = 0; cyc < 200 && fins == 0; cyc++) begin
      @(negedge clk);
      n++;
      if (win_req) begin
        if (!prev_req) begin
          run = 1; rr = win_row; rc = win_col;
        end else begin
          run++;
          n_cmp++;
          if (win_row !== rr || win_col !== rc) begin
            n_err++;
            $display("FAIL ack_delay_stable: got (%0d,%0d) expected (%0d,%0d)", win_row, win_col, rr, rc);
          end
        end
        n_cmp++;
        if (mac_start !== 1'b0) begin
          n_err++;
          $display("FAIL ack_delay_early_mac: got mac_start=%b expected 0", mac_start);
        end
      end else if (prev_req) begin
        n_cmp++;
        if (run != 3 || mac_start !== 1'b1) begin
          n_err++;
          $display("FAIL ack_delay_req_len: got %0d cycles mac_start=%b expected 3 cycles mac_start=1", run, mac_start);
        end
      end
      prev_req = win_req;
      if (layer_0_calc_fin) begin
        fins++;
        fin_n = n;
      end
    end
    n_cmp++;
    if (fin_n != MIN_CYC + OD * OD * 2 || extra_total - x0 != OD * OD * 2) begin
      n_err++;
      $display("FAIL ack_delay_latency: got %0d expected %0d", fin_n, MIN_CYC + OD * OD * 2);
    end
    @(negedge clk);
    layer_0_en = 1'b0;
    mode = M_ZERO;
    repeat (3) @(negedge clk);
  endtask

  // Random ack/done latencies over several separately enabled images.
  task automatic test_random_latency();
    mode = M_LAT;
    ack_min = 0; ack_max = 3; done_min = 0; done_max = 3;
    for (int img = 0; img < 4; img++) begin
      int er[$], ec[$], ek[$];
      int n, fins, fin_n, x0;
      for (int r = 0; r < OD; r++)
        for (int c = 0; c < OD; c++)
          for (int k = 0; k < KN; k++) begin
            er.push_back(r); ec.push_back(c); ek.push_back(k);
          end
      x0 = extra_total;
      @(negedge clk);
      layer_0_en = 1'b1;
      n = 1; fins = 0; fin_n = 0;
      for (int cyc = 0; cyc < 300 && fins == 0; cyc++) begin
        @(negedge clk);
        n++;
        if (mac_start) begin
          n_cmp++;
          if (er.size() == 0) begin
            n_err++;
            $display("FAIL rand_mac_extra: img %0d got mac_start expected none", img);
          end else begin
            if (int'(win_row) != er[0] || int'(win_col) != ec[0] || int'(kernel_idx) != ek[0]) begin
              n_err++;
              $display("FAIL rand_mac_order: img %0d got (%0d,%0d,k%0d) expected (%0d,%0d,k%0d)",
                       img, win_row, win_col, kernel_idx, er[0], ec[0], ek[0]);
            end
            void'(er.pop_front()); void'(ec.pop_front()); void'(ek.pop_front());
          end
        end
        if (layer_0_calc_fin) begin
          fins++;
          fin_n = n;
        end
      end
      n_cmp++;
      if (fin_n != MIN_CYC + (extra_total - x0) || er.size() != 0) begin
        n_err++;
        $display("FAIL rand_latency: img %0d got %0d cycles (%0d MACs left) expected %0d",
                 img, fin_n, er.size(), MIN_CYC + (extra_total - x0));
      end
      @(negedge clk);
      layer_0_en = 1'b0;
`ifdef LAYER_0_PERF_CNT_EN
      n_cmp++;
      if (perf_cycles !== 32'(MIN_CYC + (extra_total - x0))) begin
        n_err++;
        $display("FAIL rand_perf: img %0d got %0d expected %0d", img, perf_cycles, MIN_CYC + (extra_total - x0));
      end
`endif
      repeat (2) @(negedge clk);
    end
    mode = M_ZERO;
  endtask

  // Enable held over three images: relaunch right after each finish.
  task automatic test_back_to_back();
    int n, fins, cd, bad_idle;
    int fin_at[3];
    mode = M_ONE;
    @(negedge clk);
    layer_0_en = 1'b1;
    n = 1; fins = 0; cd = 0;
    fin_at[0] = 0; fin_at[1] = 0; fin_at[2] = 0;
    for (int cyc = 0; cyc < 200 && fins < 3; cyc++) begin
      @(negedge clk);
      n++;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          n_cmp++;
          if (win_req !== 1'b1 || win_row !== '0 || win_col !== '0) begin
            n_err++;
            $display("FAIL b2b_relaunch: got req=%b (%0d,%0d) expected req=1 (0,0)", win_req, win_row, win_col);
          end
        end
      end
      if (layer_0_calc_fin) begin
        fin_at[fins] = n;
        fins++;
        cd = 2;
      end
    end
    n_cmp++;
    if (fins != 3 || fin_at[0] != MIN_CYC || fin_at[1] - fin_at[0] != MIN_CYC || fin_at[2] - fin_at[1] != MIN_CYC) begin
      n_err++;
      $display("FAIL b2b_fin_times: got %0d pulses at %0d,%0d,%0d expected 3 at %0d,%0d,%0d",
               fins, fin_at[0], fin_at[1], fin_at[2], MIN_CYC, 2 * MIN_CYC, 3 * MIN_CYC);
    end
    @(negedge clk);
    layer_0_en = 1'b0;
    bad_idle = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || win_req || layer_0_calc_fin) bad_idle++;
    end
    n_cmp++;
    if (bad_idle != 0) begin
      n_err++;
      $display("FAIL b2b_final_idle: got %0d active cycles expected 0", bad_idle);
    end
  endtask

  // Enable dropped while waiting on kernel 1 of window (1,0), then restart.
  task automatic test_abort();
    bit hit, seen_req, seen_mac;
    int bad;
    mode = M_LAT;
    ack_min = 0; ack_max = 0; done_min = 3; done_max = 3;
    @(negedge clk);
    layer_0_en = 1'b1;
    hit = 0;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      @(negedge clk);
      if (busy && !win_req && !mac_start && !layer_0_calc_fin &&
          int'(win_row) == 1 && int'(win_col) == 0 && int'(kernel_idx) == 1) begin
        hit = 1;
        layer_0_en = 1'b0;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL abort_reach: got no wait at (1,0,k1) expected one");
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || win_row !== '0 || win_col !== '0 || kernel_idx !== '0) begin
      n_err++;
      $display("FAIL abort_clear: got busy=%b (%0d,%0d,k%0d) expected 0 (0,0,k0)", busy, win_row, win_col, kernel_idx);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || layer_0_calc_fin || mac_start) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL abort_no_fin: got %0d active cycles expected 0", bad);
    end
    mode = M_ONE;
    layer_0_en = 1'b1;
    seen_req = 0; seen_mac = 0;
    for (int cyc = 0; cyc < 20 && !seen_mac; cyc++) begin
      @(negedge clk);
      if (win_req && !seen_req) begin
        seen_req = 1;
        n_cmp++;
        if (win_row !== '0 || win_col !== '0) begin
          n_err++;
          $display("FAIL abort_restart_win: got (%0d,%0d) expected (0,0)", win_row, win_col);
        end
      end
      if (mac_start) begin
        seen_mac = 1;
        n_cmp++;
        if (kernel_idx !== '0 || win_row !== '0 || win_col !== '0) begin
          n_err++;
          $display("FAIL abort_restart_mac: got (%0d,%0d,k%0d) expected (0,0,k0)", win_row, win_col, kernel_idx);
        end
      end
    end
    n_cmp++;
    if (!seen_req || !seen_mac) begin
      n_err++;
      $display("FAIL abort_restart_timeout: got req=%0d mac=%0d expected 1 1", seen_req, seen_mac);
    end
    layer_0_en = 1'b0;
    mode = M_ZERO;
    repeat (3) @(negedge clk);
  endtask

  // Stray mac_done in LOAD, simultaneous ack/done, then reset during CALC.
  task automatic test_stray_and_reset();
    mode = M_MAN;
    man_ack = 1'b0; man_done = 1'b0;
    @(negedge clk);
    layer_0_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (win_req !== 1'b1) begin
      n_err++;
      $display("FAIL stray_load_entry: got req=%b expected 1", win_req);
    end
    man_done = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (win_req !== 1'b1 || kernel_idx !== '0 || mac_start !== 1'b0) begin
      n_err++;
      $display("FAIL stray_done_load: got req=%b k=%0d start=%b expected 1 0 0", win_req, kernel_idx, mac_start);
    end
    man_ack = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mac_start !== 1'b1 || win_req !== 1'b0 || kernel_idx !== '0) begin
      n_err++;
      $display("FAIL stray_ack_and_done: got start=%b req=%b k=%0d expected 1 0 0", mac_start, win_req, kernel_idx);
    end
    rst_n = 1'b0;
    man_ack = 1'b0; man_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({win_req, win_row, win_col, mac_start, kernel_idx, layer_0_calc_fin, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_in_calc: got %b expected all zero",
               {win_req, win_row, win_col, mac_start, kernel_idx, layer_0_calc_fin, busy});
    end
    rst_n = 1'b1;
    layer_0_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: got busy=%b expected 0", busy);
    end
    mode = M_ZERO;
  endtask

`ifdef LAYER_0_PERF_CNT_EN
  // Minimum-latency image sets the counter; an aborted run leaves it alone.
  task automatic test_perf();
    int fins;
    mode = M_ONE;
    @(negedge clk);
    layer_0_en = 1'b1;
    fins = 0;
    for (int cyc = 0; cyc < 100 && fins == 0; cyc++) begin
      @(negedge clk);
      if (layer_0_calc_fin) fins++;
    end
    @(negedge clk);
    layer_0_en = 1'b0;
    n_cmp++;
    if (perf_cycles !== 32'(MIN_CYC)) begin
      n_err++;
      $display("FAIL perf_image: got %0d expected %0d", perf_cycles, MIN_CYC);
    end
    repeat (2) @(negedge clk);
    layer_0_en = 1'b1;
    repeat (9) @(negedge clk);
    layer_0_en = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (perf_cycles !== 32'(MIN_CYC)) begin
      n_err++;
      $display("FAIL perf_abort: got %0d expected %0d", perf_cycles, MIN_CYC);
    end
    mode = M_ZERO;
  endtask
`endif

  initial begin
    test_reset();
    test_single_image();
    test_ack_delay();
    test_random_latency();
    test_back_to_back();
    test_abort();
    test_stray_and_reset();
`ifdef LAYER_0_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
